// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS main control FSM; BNE support is compiled in with MC_BNE_EN.
// One state per cycle; stalls in FETCH/MEMRD/MEMWR until mem_ready (FETCH pcwrite/irwrite gated by it).
module mc_controller #(
  parameter int ILLEGAL_HALT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       illegal,
`ifdef MC_BNE_EN
  output logic       bne,
`endif
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    INIT    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEMADR  = 4'd3,
    MEMRD   = 4'd4,
    MEMWB   = 4'd5,
    MEMWR   = 4'd6,
    RTYPEEX = 4'd7,
    RTYPEWB = 4'd8,
    BEQEX   = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11,
    JEX     = 4'd12,
    HALT    = 4'd13,
    BNEEX   = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  state_t state;
  state_t state_nxt;
  logic   illegal_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Sticky until reset; HALT relies on this flag being the only live output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal <= 1'b0;
    end else if (illegal_set) begin
      illegal <= 1'b1;
    end
  end

  assign state_dbg = state;

  always_comb begin
    state_nxt   = INIT;
    illegal_set = 1'b0;
    mem_req     = 1'b0;
    iord        = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    pcwrite     = 1'b0;
    branch      = 1'b0;
    pcsrc       = 2'b00;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
`ifdef MC_BNE_EN
    bne         = 1'b0;
`endif

    case (state)
      INIT: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        // PC+4 is written in the same cycle the instruction lands in IR.
        mem_req   = 1'b1;
        alusrcb   = 2'b01;
        pcwrite   = mem_ready;
        irwrite   = mem_ready;
        state_nxt = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // ALU precomputes the branch target into ALUOut here.
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = RTYPEEX;
          OP_BEQ:       state_nxt = BEQEX;
          OP_ADDI:      state_nxt = ADDIEX;
          OP_J:         state_nxt = JEX;
`ifdef MC_BNE_EN
          OP_BNE:       state_nxt = BNEEX;
`endif
          default: begin
            illegal_set = 1'b1;
            state_nxt   = (ILLEGAL_HALT != 0) ? HALT : FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        state_nxt = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        state_nxt = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg  = 1'b1;
        regwrite  = 1'b1;
        state_nxt = FETCH;
      end
      MEMWR: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        memwrite  = 1'b1;
        state_nxt = mem_ready ? FETCH : MEMWR;
      end
      RTYPEEX: begin
        alusrca   = 1'b1;
        aluop     = 2'b10;
        state_nxt = RTYPEWB;
      end
      RTYPEWB: begin
        regdst    = 1'b1;
        regwrite  = 1'b1;
        state_nxt = FETCH;
      end
      BEQEX: begin
        alusrca   = 1'b1;
        aluop     = 2'b01;
        pcsrc     = 2'b01;
        branch    = 1'b1;
        state_nxt = FETCH;
      end
      ADDIEX: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        state_nxt = ADDIWB;
      end
      ADDIWB: begin
        regwrite  = 1'b1;
        state_nxt = FETCH;
      end
      JEX: begin
        pcsrc     = 2'b10;
        pcwrite   = 1'b1;
        state_nxt = FETCH;
      end
      HALT: begin
        state_nxt = HALT;
      end
`ifdef MC_BNE_EN
      BNEEX: begin
        alusrca   = 1'b1;
        aluop     = 2'b01;
        pcsrc     = 2'b01;
        branch    = 1'b1;
        bne       = 1'b1;
        state_nxt = FETCH;
      end
`endif
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus pushes expected state/outputs, monitor pops and compares.
module tb_mc_controller;

  localparam logic [5:0] OP_RT  = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_ready;
  logic [5:0] op;

  logic       d_mem_req, d_iord, d_memwrite, d_irwrite, d_pcwrite, d_branch;
  logic [1:0] d_pcsrc, d_alusrcb, d_aluop;
  logic       d_alusrca, d_regdst, d_memtoreg, d_regwrite, d_illegal, d_bne;
  logic [3:0] d_state;

  logic       h_mem_req, h_iord, h_memwrite, h_irwrite, h_pcwrite, h_branch;
  logic [1:0] h_pcsrc, h_alusrcb, h_aluop;
  logic       h_alusrca, h_regdst, h_memtoreg, h_regwrite, h_illegal, h_bne;
  logic [3:0] h_state;

  always #5 clk = ~clk;

  mc_controller #(.ILLEGAL_HALT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .mem_req(d_mem_req), .iord(d_iord), .memwrite(d_memwrite), .irwrite(d_irwrite),
    .pcwrite(d_pcwrite), .branch(d_branch), .pcsrc(d_pcsrc), .alusrca(d_alusrca),
    .alusrcb(d_alusrcb), .aluop(d_aluop), .regdst(d_regdst), .memtoreg(d_memtoreg),
    .regwrite(d_regwrite), .illegal(d_illegal),
`ifdef MC_BNE_EN
    .bne(d_bne),
`endif
    .state_dbg(d_state)
  );

  mc_controller #(.ILLEGAL_HALT(1)) u_halt (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .mem_req(h_mem_req), .iord(h_iord), .memwrite(h_memwrite), .irwrite(h_irwrite),
    .pcwrite(h_pcwrite), .branch(h_branch), .pcsrc(h_pcsrc), .alusrca(h_alusrca),
    .alusrcb(h_alusrcb), .aluop(h_aluop), .regdst(h_regdst), .memtoreg(h_memtoreg),
    .regwrite(h_regwrite), .illegal(h_illegal),
`ifdef MC_BNE_EN
    .bne(h_bne),
`endif
    .state_dbg(h_state)
  );

`ifndef MC_BNE_EN
  assign d_bne = 1'b0;
  assign h_bne = 1'b0;
`endif

  logic [16:0] d_vec, h_vec;
  assign d_vec = {d_bne, d_mem_req, d_iord, d_memwrite, d_irwrite, d_pcwrite, d_branch, d_pcsrc,
                  d_alusrca, d_alusrcb, d_aluop, d_regdst, d_memtoreg, d_regwrite};
  assign h_vec = {h_bne, h_mem_req, h_iord, h_memwrite, h_irwrite, h_pcwrite, h_branch, h_pcsrc,
                  h_alusrca, h_alusrcb, h_aluop, h_regdst, h_memtoreg, h_regwrite};

  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic       ill;
  } exp_t;

  exp_t q[$];
  exp_t hq[$];
  exp_t me;
  exp_t mh;
  event smp;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic cur_ill;

  // Expected output vector per state, written from the state/output table.
  function automatic logic [16:0] exp_out(input logic [3:0] st, input logic rdy);
    logic [16:0] v;
    v = '0;
    case (st)
      4'd1:  begin v[15] = 1'b1; v[6:5] = 2'b01; v[12] = rdy; v[11] = rdy; end
      4'd2:  begin v[6:5] = 2'b11; end
      4'd3:  begin v[7] = 1'b1; v[6:5] = 2'b10; end
      4'd4:  begin v[15] = 1'b1; v[14] = 1'b1; end
      4'd5:  begin v[1] = 1'b1; v[0] = 1'b1; end
      4'd6:  begin v[15] = 1'b1; v[14] = 1'b1; v[13] = 1'b1; end
      4'd7:  begin v[7] = 1'b1; v[4:3] = 2'b10; end
      4'd8:  begin v[2] = 1'b1; v[0] = 1'b1; end
      4'd9:  begin v[7] = 1'b1; v[4:3] = 2'b01; v[9:8] = 2'b01; v[10] = 1'b1; end
      4'd10: begin v[7] = 1'b1; v[6:5] = 2'b10; end
      4'd11: begin v[0] = 1'b1; end
      4'd12: begin v[9:8] = 2'b10; v[11] = 1'b1; end
      4'd14: begin v[7] = 1'b1; v[4:3] = 2'b01; v[9:8] = 2'b01; v[10] = 1'b1; v[16] = 1'b1; end
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic push_exp(input logic [3:0] st, input logic rdy, input logic ill, input bit to_halt);
    exp_t e;
    e.st  = st;
    e.rdy = rdy;
    e.ill = ill;
    if (to_halt) hq.push_back(e);
    else         q.push_back(e);
  endtask

  // Monitor: compares the DUT against whatever the stimulus queued for this cycle.
  always begin
    @(negedge clk or smp);
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("dut_state", {13'd0, d_state}, {13'd0, me.st});
      chk("dut_outputs", d_vec, exp_out(me.st, me.rdy));
      chk("dut_illegal", {16'd0, d_illegal}, {16'd0, me.ill});
    end
    if (hq.size() > 0) begin
      mh = hq.pop_front();
      chk("halt_state", {13'd0, h_state}, {13'd0, mh.st});
      chk("halt_outputs", h_vec, exp_out(mh.st, mh.rdy));
      chk("halt_illegal", {16'd0, h_illegal}, {16'd0, mh.ill});
    end
  end

  // One cycle: drive inputs just after the edge, queue the state expected for this cycle.
  task automatic step(input logic rdy, input logic [5:0] o, input logic [3:0] st, input bit h = 1'b0);
    @(posedge clk);
    #1;
    mem_ready = rdy;
    op        = o;
    push_exp(st, rdy, cur_ill, 1'b0);
    if (h) push_exp(4'd13, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
  endtask

  // Assert reset mid-cycle and check the outputs drop before any clock edge.
  task automatic do_reset(input bit with_halt);
    #2;
    rst_n   = 1'b0;
    cur_ill = 1'b0;
    push_exp(4'd0, mem_ready, 1'b0, 1'b0);
    if (with_halt) push_exp(4'd0, 1'b0, 1'b0, 1'b1);
    #1;
    -> smp;
  endtask

  task automatic reset_release();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    mem_ready = 1'b0;
    op        = OP_RT;
    cur_ill   = 1'b0;
    push_exp(4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    op        = OP_RT;
    cur_ill   = 1'b0;
    reset_release();

    // Reset in the middle of a stalled fetch.
    step(1'b0, OP_RT, 4'd1);
    do_reset(1'b0);
    reset_release();

    // lw: 3 stall cycles in FETCH, 2 in MEMRD.
    step(1'b0, OP_LW, 4'd1);
    step(1'b0, OP_LW, 4'd1);
    step(1'b0, OP_LW, 4'd1);
    step(1'b1, OP_LW, 4'd1);
    step(1'b0, OP_LW, 4'd2);
    step(1'b0, OP_LW, 4'd3);
    step(1'b0, OP_LW, 4'd4);
    step(1'b0, OP_LW, 4'd4);
    step(1'b1, OP_LW, 4'd4);
    step(1'b0, OP_LW, 4'd5);

    // R-type, no stalls.
    step(1'b1, OP_RT, 4'd1);
    step(1'b1, OP_RT, 4'd2);
    step(1'b1, OP_RT, 4'd7);
    step(1'b1, OP_RT, 4'd8);

    // sw, beq, j.
    step(1'b1, OP_SW, 4'd1);
    step(1'b1, OP_SW, 4'd2);
    step(1'b1, OP_SW, 4'd3);
    step(1'b1, OP_SW, 4'd6);
    step(1'b1, OP_BEQ, 4'd1);
    step(1'b1, OP_BEQ, 4'd2);
    step(1'b1, OP_BEQ, 4'd9);
    step(1'b1, OP_J, 4'd1);
    step(1'b1, OP_J, 4'd2);
    step(1'b1, OP_J, 4'd12);

    // Unknown opcode: one instance refetches, the other halts for good.
    step(1'b1, OP_BAD, 4'd1);
    step(1'b1, OP_BAD, 4'd2);
    cur_ill = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, OP_BAD, (i % 2 == 0) ? 4'd1 : 4'd2, 1'b1);
    end
    do_reset(1'b1);
    reset_release();

    // bne opcode.
    step(1'b1, OP_BNE, 4'd1);
    step(1'b1, OP_BNE, 4'd2);
`ifdef MC_BNE_EN
    step(1'b1, OP_RT, 4'd14);
    step(1'b1, OP_RT, 4'd1);
`else
    cur_ill = 1'b1;
    step(1'b1, OP_RT, 4'd1);
    step(1'b1, OP_RT, 4'd2);
`endif

    for (int i = 0; i < 10; i++) begin
      if (q.size() == 0 && hq.size() == 0) break;
      @(negedge clk);
    end
    if (q.size() != 0 || hq.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size() + hq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
